// File: rtl/network_bf_in_pkg.sv
// network_bf_in_pkg: shared widths, bank indices and latency default for the NTT read crossbar
package network_bf_in_pkg;
    localparam int NTT_DW      = 14;
    localparam int SEL_W       = 3;
    localparam int NUM_OPS     = 8;
    localparam int NUM_PAIRS   = NUM_OPS * (NUM_OPS - 1) / 2;
    localparam int DEF_MEM_LAT = 1;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t BF0_LO = 3'd0;
    localparam sel_t BF0_UP = 3'd1;
    localparam sel_t BF1_LO = 3'd2;
    localparam sel_t BF1_UP = 3'd3;
    localparam sel_t BF2_LO = 3'd4;
    localparam sel_t BF2_UP = 3'd5;
    localparam sel_t BF3_LO = 3'd6;
    localparam sel_t BF3_UP = 3'd7;

    // flat index of the unordered pair (i, j), i < j, into a NUM_PAIRS-wide vector
    function automatic int pair_idx(input int i, input int j);
        return i * (2 * NUM_OPS - 1 - i) / 2 + j - i - 1;
    endfunction
endpackage

// File: rtl/shift_n.sv
// shift_n: depth-stage register delay line, cleared by asynchronous active-low reset
module shift_n #(
    parameter int data_width = 1,
    parameter int depth      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] d,
    output logic [data_width-1:0] q
);
    logic [data_width-1:0] stage [depth];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= '{default: '0};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < depth; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[depth-1];
endmodule

// File: rtl/network_bf_in.sv
// network_bf_in: read-side crossbar routing 8 bank words to the 4 BFU operand pairs,
// with selects aligned to bank read latency and a sticky routing-conflict flag
module network_bf_in
    import network_bf_in_pkg::*;
#(
    parameter int DATA_WIDTH = NTT_DW,
    parameter int MEM_LAT    = DEF_MEM_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ren,
    input  logic [SEL_W-1:0]      sel_b_0,
    input  logic [SEL_W-1:0]      sel_b_1,
    input  logic [SEL_W-1:0]      sel_b_2,
    input  logic [SEL_W-1:0]      sel_b_3,
    input  logic [SEL_W-1:0]      sel_b_4,
    input  logic [SEL_W-1:0]      sel_b_5,
    input  logic [SEL_W-1:0]      sel_b_6,
    input  logic [SEL_W-1:0]      sel_b_7,
    input  logic [DATA_WIDTH-1:0] q0,
    input  logic [DATA_WIDTH-1:0] q1,
    input  logic [DATA_WIDTH-1:0] q2,
    input  logic [DATA_WIDTH-1:0] q3,
    input  logic [DATA_WIDTH-1:0] q4,
    input  logic [DATA_WIDTH-1:0] q5,
    input  logic [DATA_WIDTH-1:0] q6,
    input  logic [DATA_WIDTH-1:0] q7,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] bf_0_upper,
    output logic [DATA_WIDTH-1:0] bf_0_lower,
    output logic [DATA_WIDTH-1:0] bf_1_upper,
    output logic [DATA_WIDTH-1:0] bf_1_lower,
    output logic [DATA_WIDTH-1:0] bf_2_upper,
    output logic [DATA_WIDTH-1:0] bf_2_lower,
    output logic [DATA_WIDTH-1:0] bf_3_upper,
    output logic [DATA_WIDTH-1:0] bf_3_lower,
    output logic                  bf_valid,
    output logic                  conflict_err
);
    localparam int LINE_W = SEL_W * NUM_OPS + 1;

    logic [LINE_W-1:0]     line_in, line_out;
    logic                  ren_a;
    sel_t                  sel_a [NUM_OPS];
    logic [DATA_WIDTH-1:0] q     [NUM_OPS];
    logic [DATA_WIDTH-1:0] op    [NUM_OPS];
    logic [DATA_WIDTH-1:0] bf_r  [NUM_OPS];
    logic [NUM_PAIRS-1:0]  eq;

    assign line_in = {ren, sel_b_7, sel_b_6, sel_b_5, sel_b_4, sel_b_3, sel_b_2, sel_b_1, sel_b_0};
    assign q       = '{q0, q1, q2, q3, q4, q5, q6, q7};

    shift_n #(.data_width(LINE_W), .depth(MEM_LAT)) u_align (
        .clk (clk),
        .rst (rst),
        .d   (line_in),
        .q   (line_out)
    );

    assign ren_a = line_out[LINE_W-1];

    genvar i, j;
    for (i = 0; i < NUM_OPS; i++) begin : g_op
        assign sel_a[i] = line_out[i*SEL_W +: SEL_W];
        assign op[i]    = q[sel_a[i]];
        for (j = i + 1; j < NUM_OPS; j++) begin : g_cmp
            assign eq[pair_idx(i, j)] = sel_a[i] == sel_a[j];
        end
    end

    // a conflicting beat is still routed; the flag only reports it, and set beats clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bf_r         <= '{default: '0};
            bf_valid     <= 1'b0;
            conflict_err <= 1'b0;
        end else begin
            if (ren_a) bf_r <= op;
            bf_valid     <= ren_a;
            conflict_err <= (ren_a && |eq) || (conflict_err && !err_clr);
        end
    end

    assign bf_0_lower = bf_r[BF0_LO];
    assign bf_0_upper = bf_r[BF0_UP];
    assign bf_1_lower = bf_r[BF1_LO];
    assign bf_1_upper = bf_r[BF1_UP];
    assign bf_2_lower = bf_r[BF2_LO];
    assign bf_2_upper = bf_r[BF2_UP];
    assign bf_3_lower = bf_r[BF3_LO];
    assign bf_3_upper = bf_r[BF3_UP];
endmodule

// File: tb/tb_network_bf_in.sv
// tb_network_bf_in: drives four crossbars (MEM_LAT 1,3,4,8) with shared stimulus and
// checks every beat against a history-based reference of the routing rules
module tb_network_bf_in;
    localparam int NI = 4;
    localparam int HN = 1024;

    function automatic int lat(input int g);
        return g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 8;
    endfunction

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ren = 1'b0;
    logic             err_clr = 1'b0;
    logic [7:0][2:0]  sel = '0;
    logic [7:0][13:0] qv = '0;
    logic [13:0]      bf_o [NI][8];
    logic             valid_o [NI];
    logic             err_o [NI];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < NI; g++) begin : g_dut
        network_bf_in #(.DATA_WIDTH(14), .MEM_LAT(lat(g))) u_dut (
            .clk          (clk),
            .rst          (rst),
            .ren          (ren),
            .sel_b_0      (sel[0]),
            .sel_b_1      (sel[1]),
            .sel_b_2      (sel[2]),
            .sel_b_3      (sel[3]),
            .sel_b_4      (sel[4]),
            .sel_b_5      (sel[5]),
            .sel_b_6      (sel[6]),
            .sel_b_7      (sel[7]),
            .q0           (qv[0]),
            .q1           (qv[1]),
            .q2           (qv[2]),
            .q3           (qv[3]),
            .q4           (qv[4]),
            .q5           (qv[5]),
            .q6           (qv[6]),
            .q7           (qv[7]),
            .err_clr      (err_clr),
            .bf_0_upper   (bf_o[g][1]),
            .bf_0_lower   (bf_o[g][0]),
            .bf_1_upper   (bf_o[g][3]),
            .bf_1_lower   (bf_o[g][2]),
            .bf_2_upper   (bf_o[g][5]),
            .bf_2_lower   (bf_o[g][4]),
            .bf_3_upper   (bf_o[g][7]),
            .bf_3_lower   (bf_o[g][6]),
            .bf_valid     (valid_o[g]),
            .conflict_err (err_o[g])
        );
    end

    // history of what was presented at each edge; the model looks back MEM_LAT edges
    bit               ren_h [HN];
    logic [7:0][2:0]  sel_h [HN];
    logic [13:0]      exp_bf [NI][8];
    bit               exp_v [NI];
    bit               exp_e [NI];
    int               n = 16;
    int               total = 0;
    int               bad = 0;

    logic [7:0][2:0]  id_s, rev_s, cf_s;
    logic [7:0][13:0] q100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_perm(input logic [7:0][2:0] s);
        logic [7:0] seen;
        seen = '0;
        for (int k = 0; k < 8; k++) seen[s[k]] = 1'b1;
        return &seen;
    endfunction

    function automatic logic [7:0][2:0] rand_perm();
        logic [7:0][2:0] p;
        logic [2:0]      t;
        int              r;
        for (int k = 0; k < 8; k++) p[k] = 3'(k);
        for (int k = 7; k > 0; k--) begin
            r = $urandom_range(k, 0);
            t = p[k];
            p[k] = p[r];
            p[r] = t;
        end
        return p;
    endfunction

    function automatic logic [7:0][2:0] rand_sel();
        return 24'($urandom());
    endfunction

    function automatic logic [7:0][13:0] rand_q();
        logic [7:0][13:0] r;
        for (int k = 0; k < 8; k++) r[k] = 14'($urandom_range(16383, 0));
        return r;
    endfunction

    task automatic step(input bit r, input logic [7:0][2:0] s, input logic [7:0][13:0] qq, input bit c);
        int m;
        bit v;
        ren = r;
        sel = s;
        qv = qq;
        err_clr = c;
        n++;
        ren_h[n] = r;
        sel_h[n] = s;
        @(posedge clk);
        @(negedge clk);
        for (int gi = 0; gi < NI; gi++) begin
            m = n - lat(gi);
            v = ren_h[m];
            if (v) for (int k = 0; k < 8; k++) exp_bf[gi][k] = qq[sel_h[m][k]];
            exp_e[gi] = (v && !is_perm(sel_h[m])) || (exp_e[gi] && !c);
            exp_v[gi] = v;
            chk($sformatf("L%0d bf_valid", lat(gi)), 32'(valid_o[gi]), 32'(exp_v[gi]));
            chk($sformatf("L%0d conflict_err", lat(gi)), 32'(err_o[gi]), 32'(exp_e[gi]));
            for (int k = 0; k < 8; k++)
                chk($sformatf("L%0d op%0d", lat(gi), k), 32'(bf_o[gi][k]), 32'(exp_bf[gi][k]));
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(1'b0, rand_sel(), rand_q(), 1'b0);
    endtask

    task automatic check_zero(input string tag);
        for (int gi = 0; gi < NI; gi++) begin
            chk($sformatf("%s L%0d bf_valid", tag, lat(gi)), 32'(valid_o[gi]), 32'd0);
            chk($sformatf("%s L%0d conflict_err", tag, lat(gi)), 32'(err_o[gi]), 32'd0);
            for (int k = 0; k < 8; k++)
                chk($sformatf("%s L%0d op%0d", tag, lat(gi), k), 32'(bf_o[gi][k]), 32'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            id_s[k] = 3'(k);
            rev_s[k] = 3'(7 - k);
            q100[k] = 14'(100 + k);
        end
        cf_s = id_s;
        cf_s[0] = 3'd3;
        cf_s[5] = 3'd3;
        for (int gi = 0; gi < NI; gi++) begin
            exp_v[gi] = 1'b0;
            exp_e[gi] = 1'b0;
            for (int k = 0; k < 8; k++) exp_bf[gi][k] = '0;
        end

        // power-on reset
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // identity routing
        step(1'b1, id_s, rand_q(), 1'b0);
        step(1'b0, rand_sel(), q100, 1'b0);
        chk("ident bf_valid", 32'(valid_o[0]), 32'd1);
        chk("ident bf_0_lower", 32'(bf_o[0][0]), 32'd100);
        chk("ident bf_0_upper", 32'(bf_o[0][1]), 32'd101);
        chk("ident bf_3_upper", 32'(bf_o[0][7]), 32'd107);
        chk("ident conflict_err", 32'(err_o[0]), 32'd0);

        // reversed routing
        step(1'b1, rev_s, rand_q(), 1'b0);
        step(1'b0, rand_sel(), q100, 1'b0);
        chk("rev bf_0_lower", 32'(bf_o[0][0]), 32'd107);
        chk("rev bf_3_upper", 32'(bf_o[0][7]), 32'd100);
        idle(9);

        // back-to-back beats then hold
        repeat (3) step(1'b1, rand_perm(), rand_q(), 1'b0);
        idle(10);

        // conflict, sticky across clean beats, cleared by err_clr
        step(1'b1, cf_s, rand_q(), 1'b0);
        step(1'b0, rand_sel(), q100, 1'b0);
        chk("conf bf_0_lower", 32'(bf_o[0][0]), 32'd103);
        chk("conf bf_2_upper", 32'(bf_o[0][5]), 32'd103);
        chk("conf conflict_err", 32'(err_o[0]), 32'd1);
        repeat (3) step(1'b1, rand_perm(), rand_q(), 1'b0);
        idle(10);
        for (int gi = 0; gi < NI; gi++) chk($sformatf("sticky L%0d", lat(gi)), 32'(err_o[gi]), 32'd1);
        step(1'b0, rand_sel(), rand_q(), 1'b1);
        for (int gi = 0; gi < NI; gi++) chk($sformatf("clear L%0d", lat(gi)), 32'(err_o[gi]), 32'd0);

        // err_clr together with a new conflict: set wins
        step(1'b1, cf_s, rand_q(), 1'b0);
        step(1'b0, rand_sel(), rand_q(), 1'b1);
        chk("set wins L1", 32'(err_o[0]), 32'd1);
        idle(10);
        step(1'b0, rand_sel(), rand_q(), 1'b1);
        idle(2);

        // reset mid-flight discards in-flight beats
        step(1'b1, rand_perm(), rand_q(), 1'b0);
        step(1'b1, rand_perm(), rand_q(), 1'b0);
        ren = 1'b0;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        for (int i = 0; i < HN; i++) ren_h[i] = 1'b0;
        for (int gi = 0; gi < NI; gi++) begin
            exp_v[gi] = 1'b0;
            exp_e[gi] = 1'b0;
            for (int k = 0; k < 8; k++) exp_bf[gi][k] = '0;
        end
        @(negedge clk);
        rst = 1'b1;
        idle(12);

        // random sweep across all latencies
        repeat (250) begin
            step($urandom_range(9, 0) < 7,
                 $urandom_range(9, 0) == 0 ? rand_sel() : rand_perm(),
                 rand_q(),
                 $urandom_range(19, 0) == 0);
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
